// File: rtl/requant_pkg.sv
// Shared types, default geometry and the output saturation helper for the
// requantisation pipeline.
package requant_pkg;

    typedef enum logic {
        MODE_INT4 = 1'b0,
        MODE_INT8 = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_LANES      = 16;
    localparam int DEF_ACC_W      = 24;
    localparam int DEF_SCALE_W    = 16;
    localparam int DEF_SCALE_FRAC = 10;
    localparam int DEF_BIAS_W     = 16;
    localparam int DEF_OUT_W      = 8;
    localparam int DEF_BEATS      = 16;
    localparam int DEF_DEPTH      = 64;

    // Saturated results always fit in a signed byte; callers widen to their slot.
    localparam int SAT_W    = 8;
    localparam int SAT_IN_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_IN_W-1:0] value,
        input mode_t                      mode
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        if (mode == MODE_INT8) begin
            hi = SAT_IN_W'(127);
            lo = SAT_IN_W'(-128);
        end else begin
            hi = SAT_IN_W'(7);
            lo = SAT_IN_W'(-8);
        end
        if (value > hi) begin
            return hi[SAT_W-1:0];
        end else if (value < lo) begin
            return lo[SAT_W-1:0];
        end else begin
            return value[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requant datapath: bias add, scale multiply, then
// round-half-up with per-beat INT4/INT8 saturation.
module requant_lane
    import requant_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int SCALE_W    = DEF_SCALE_W,
    parameter int SCALE_FRAC = DEF_SCALE_FRAC,
    parameter int BIAS_W     = DEF_BIAS_W,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en1,
    input  logic               i_en2,
    input  logic               i_en3,
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [BIAS_W-1:0]  i_bias,
    input  logic [SCALE_W-1:0] i_scale,
    input  mode_t              i_mode,
    output logic [OUT_W-1:0]   o_data
);

    localparam int S1_W = ACC_W + 1;
    localparam int S2_W = ACC_W + SCALE_W + 2;
    localparam logic signed [S2_W-1:0] RND_HALF = S2_W'(64'd1 << (SCALE_FRAC - 1));

    logic signed [S1_W-1:0]  s1_d;
    logic signed [S1_W-1:0]  s1_q;
    logic [SCALE_W-1:0]      scale_q;
    logic signed [S2_W-1:0]  s2_d;
    logic signed [S2_W-1:0]  s2_q;
    logic signed [S2_W-1:0]  s3_d;
    logic signed [SAT_W-1:0] sat_d;

    assign s1_d = S1_W'($signed(i_acc)) + S1_W'($signed(i_bias));

    // Scale is unsigned: a zero MSB keeps the product signed x unsigned.
    assign s2_d = S2_W'(s1_q) * S2_W'($signed({1'b0, scale_q}));

    assign s3_d  = (s2_q + RND_HALF) >>> SCALE_FRAC;
    assign sat_d = saturate(SAT_IN_W'(s3_d), i_mode);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q    <= '0;
            scale_q <= '0;
            s2_q    <= '0;
            o_data  <= '0;
        end else begin
            if (i_en1) begin
                s1_q    <= s1_d;
                scale_q <= i_scale;
            end
            if (i_en2) begin
                s2_q <= s2_d;
            end
            if (i_en3) begin
                o_data <= OUT_W'(sat_d);
            end
        end
    end

endmodule

// File: rtl/requant_pipe.sv
// Requantisation pipeline top: tile sequencing, per-beat scale/bias tables,
// and the address/mode/last sideband that travels alongside the lane datapaths.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for i_start; beats dropped; pipeline may still drain
//   ST_RUN  | accepting beats 0..BEATS-1 of the current tile
module requant_pipe
    import requant_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int SCALE_W    = DEF_SCALE_W,
    parameter int SCALE_FRAC = DEF_SCALE_FRAC,
    parameter int BIAS_W     = DEF_BIAS_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int BEATS      = DEF_BEATS,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int AW        = $clog2(DEPTH),
    localparam int IW        = $clog2(BEATS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [AW-1:0]            i_base_addr,
    input  logic                     i_acc_valid,
    input  logic [LANES*ACC_W-1:0]   i_acc_data,
    input  logic                     i_cfg_we,
    input  logic [IW-1:0]            i_cfg_idx,
    input  logic [LANES*SCALE_W-1:0] i_cfg_scale,
    input  logic [BIAS_W-1:0]        i_cfg_bias,
    output logic                     o_ram_we,
    output logic [AW-1:0]            o_ram_addr,
    output logic [LANES*OUT_W-1:0]   o_ram_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(1) << SCALE_FRAC;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] beat_q;
    mode_t         mode_q;
    logic [AW-1:0] base_q;

    logic          accept;
    logic          start_ok;
    logic          last_beat;
    logic [AW:0]   addr_sum;
    logic [AW:0]   addr_wrap;
    logic [AW-1:0] addr_cur;

    logic [LANES*SCALE_W-1:0] scale_tab [BEATS];
    logic [BIAS_W-1:0]        bias_tab  [BEATS];
    logic [LANES*SCALE_W-1:0] scale_row;
    logic [BIAS_W-1:0]        bias_cur;

    logic          v1_q, v2_q, v3_q;
    logic [AW-1:0] addr1_q, addr2_q, addr3_q;
    mode_t         mode1_q, mode2_q;
    logic          last1_q, last2_q, last3_q;

    assign accept    = (state_q == ST_RUN) && i_acc_valid;
    assign start_ok  = (state_q == ST_IDLE) && i_start;
    assign last_beat = (beat_q == IW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if (accept && last_beat) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            mode_q  <= MODE_INT4;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                beat_q <= '0;
                mode_q <= mode_t'(i_mode);
                base_q <= i_base_addr;
            end else if (accept) begin
                beat_q <= beat_q + IW'(1);
            end
        end
    end

    // Base and beat are both below DEPTH, so one conditional subtract wraps.
    assign addr_sum  = {1'b0, base_q} + (AW + 1)'(beat_q);
    assign addr_wrap = (addr_sum >= (AW + 1)'(DEPTH)) ? addr_sum - (AW + 1)'(DEPTH) : addr_sum;
    assign addr_cur  = addr_wrap[AW-1:0];

    // Registered write: a beat accepted in the same cycle still reads the old row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                scale_tab[i] <= {LANES{SCALE_ONE}};
                bias_tab[i]  <= '0;
            end
        end else if (i_cfg_we) begin
            scale_tab[i_cfg_idx] <= i_cfg_scale;
            bias_tab[i_cfg_idx]  <= i_cfg_bias;
        end
    end

    assign scale_row = scale_tab[beat_q];
    assign bias_cur  = bias_tab[beat_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            addr3_q <= '0;
            mode1_q <= MODE_INT4;
            mode2_q <= MODE_INT4;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept) begin
                addr1_q <= addr_cur;
                mode1_q <= mode_q;
                last1_q <= last_beat;
            end
            if (v1_q) begin
                addr2_q <= addr1_q;
                mode2_q <= mode1_q;
                last2_q <= last1_q;
            end
            if (v2_q) begin
                addr3_q <= addr2_q;
                last3_q <= last2_q;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        requant_lane #(
            .ACC_W      (ACC_W),
            .SCALE_W    (SCALE_W),
            .SCALE_FRAC (SCALE_FRAC),
            .BIAS_W     (BIAS_W),
            .OUT_W      (OUT_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en1   (accept),
            .i_en2   (v1_q),
            .i_en3   (v2_q),
            .i_acc   (i_acc_data[k*ACC_W +: ACC_W]),
            .i_bias  (bias_cur),
            .i_scale (scale_row[k*SCALE_W +: SCALE_W]),
            .i_mode  (mode2_q),
            .o_data  (o_ram_data[k*OUT_W +: OUT_W])
        );
    end

    assign o_ram_we   = v3_q;
    assign o_ram_addr = addr3_q;
    assign o_done     = v3_q && last3_q;
    assign o_busy     = (state_q == ST_RUN) || v1_q || v2_q || v3_q;

endmodule

// File: tb/tb_requant_pipe.sv
// Randomised bench for requant_pipe: a beat-level reference model predicts
// every RAM write, done pulse and busy level cycle by cycle.
module tb_requant_pipe;

    localparam int LANES      = 16;
    localparam int ACC_W      = 24;
    localparam int SCALE_W    = 16;
    localparam int SCALE_FRAC = 10;
    localparam int BIAS_W     = 16;
    localparam int OUT_W      = 8;
    localparam int BEATS      = 16;
    localparam int DEPTH      = 64;
    localparam int AW         = $clog2(DEPTH);
    localparam int IW         = $clog2(BEATS);
    localparam int DW         = LANES * OUT_W;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_start = 1'b0;
    logic                     i_mode = 1'b0;
    logic [AW-1:0]            i_base_addr = '0;
    logic                     i_acc_valid = 1'b0;
    logic [LANES*ACC_W-1:0]   i_acc_data = '0;
    logic                     i_cfg_we = 1'b0;
    logic [IW-1:0]            i_cfg_idx = '0;
    logic [LANES*SCALE_W-1:0] i_cfg_scale = '0;
    logic [BIAS_W-1:0]        i_cfg_bias = '0;
    logic                     o_ram_we;
    logic [AW-1:0]            o_ram_addr;
    logic [DW-1:0]            o_ram_data;
    logic                     o_busy;
    logic                     o_done;

    always #5 i_clk = ~i_clk;

    requant_pipe #(
        .LANES(LANES), .ACC_W(ACC_W), .SCALE_W(SCALE_W), .SCALE_FRAC(SCALE_FRAC),
        .BIAS_W(BIAS_W), .OUT_W(OUT_W), .BEATS(BEATS), .DEPTH(DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .i_acc_valid (i_acc_valid),
        .i_acc_data  (i_acc_data),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_idx   (i_cfg_idx),
        .i_cfg_scale (i_cfg_scale),
        .i_cfg_bias  (i_cfg_bias),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        int            due;
        int            addr;
        logic [DW-1:0] data;
        bit            done;
    } exp_t;

    exp_t pend[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    bit m_run;
    int m_cnt;
    int m_base;
    bit m_mode;
    int m_scale [BEATS][LANES];
    int m_bias  [BEATS];

    bit nx_start, nx_mode, nx_valid, nx_cfg_we;
    int nx_base, nx_cfg_idx, nx_cfg_bias;
    int nx_acc       [LANES];
    int nx_cfg_scale [LANES];

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Round half up = floor((x*scale + half) / 2^FRAC), then clamp to the mode's range.
    function automatic int requant(int acc, int bias, int scale, bit mode);
        longint p, n, q;
        int lo, hi;
        p = longint'(acc + bias) * longint'(scale);
        n = p + (longint'(1) << (SCALE_FRAC - 1));
        q = n / (longint'(1) << SCALE_FRAC);
        if (n < 0 && (n % (longint'(1) << SCALE_FRAC)) != 0) q = q - 1;
        hi = mode ? 127 : 7;
        lo = mode ? -128 : -8;
        if (q > hi) return hi;
        if (q < lo) return lo;
        return int'(q);
    endfunction

    function automatic int rand_acc(bit wide);
        int x;
        if (wide) begin
            x = int'($urandom);
            x = (x <<< 8) >>> 8;
        end else begin
            x = int'($urandom_range(600)) - 300;
        end
        return x;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_cnt = 0;
        pend.delete();
        for (int b = 0; b < BEATS; b++) begin
            m_bias[b] = 0;
            for (int k = 0; k < LANES; k++) m_scale[b][k] = 1 << SCALE_FRAC;
        end
    endtask

    // Called at a negedge: compare outputs due now, drive the next inputs,
    // advance the model, then move to the following negedge.
    task automatic tick();
        exp_t          e;
        bit            have;
        logic [DW-1:0] d;
        have = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            have = 1;
        end
        check("ram_we", o_ram_we, have);
        check("done", o_done, have && e.done);
        if (have) begin
            check("ram_addr", o_ram_addr, e.addr);
            check("ram_data", o_ram_data, e.data);
        end
        check("busy", o_busy, m_run || have || pend.size() != 0);

        i_start     = nx_start;
        i_mode      = nx_mode;
        i_base_addr = AW'(nx_base);
        i_acc_valid = nx_valid;
        for (int k = 0; k < LANES; k++) begin
            i_acc_data[k*ACC_W +: ACC_W]    = ACC_W'(nx_acc[k]);
            i_cfg_scale[k*SCALE_W +: SCALE_W] = SCALE_W'(nx_cfg_scale[k]);
        end
        i_cfg_we   = nx_cfg_we;
        i_cfg_idx  = IW'(nx_cfg_idx);
        i_cfg_bias = BIAS_W'(nx_cfg_bias);

        if (m_run && nx_valid) begin
            d = '0;
            for (int k = 0; k < LANES; k++)
                d[k*OUT_W +: OUT_W] = OUT_W'(requant(nx_acc[k], m_bias[m_cnt], m_scale[m_cnt][k], m_mode));
            pend.push_back('{cyc + 3, (m_base + m_cnt) % DEPTH, d, m_cnt == BEATS - 1});
            m_cnt++;
            if (m_cnt == BEATS) m_run = 0;
        end else if (!m_run && nx_start) begin
            m_run  = 1;
            m_cnt  = 0;
            m_mode = nx_mode;
            m_base = nx_base;
        end
        if (nx_cfg_we) begin
            m_bias[nx_cfg_idx] = nx_cfg_bias;
            for (int k = 0; k < LANES; k++) m_scale[nx_cfg_idx][k] = nx_cfg_scale[k];
        end

        nx_start  = 0;
        nx_valid  = 0;
        nx_cfg_we = 0;
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic start_tile(bit mode, int base);
        nx_start = 1;
        nx_mode  = mode;
        nx_base  = base;
        tick();
    endtask

    task automatic beat_all(int v);
        for (int k = 0; k < LANES; k++) nx_acc[k] = v;
        nx_valid = 1;
        tick();
    endtask

    task automatic beat_rand(bit wide);
        for (int k = 0; k < LANES; k++) nx_acc[k] = rand_acc(wide);
        nx_valid = 1;
        tick();
    endtask

    task automatic set_cfg(int idx, int scale, int bias);
        nx_cfg_we   = 1;
        nx_cfg_idx  = idx;
        nx_cfg_bias = bias;
        for (int k = 0; k < LANES; k++) nx_cfg_scale[k] = scale;
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_we", o_ram_we, 1'b0);
        check("rst_ram_addr", o_ram_addr, '0);
        check("rst_ram_data", o_ram_data, '0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        i_start     = 1'b0;
        i_acc_valid = 1'b0;
        i_cfg_we    = 1'b0;
        @(negedge i_clk);
        cyc++;
        i_rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < LANES; k++) begin
            nx_acc[k] = 0;
            nx_cfg_scale[k] = 0;
        end
        repeat (2) @(negedge i_clk);
        check_reset_outputs();
        i_rst_n = 1'b1;
        idle(1);

        // Default tables, INT4, base 0, constant 5.
        start_tile(0, 0);
        for (int b = 0; b < BEATS; b++) beat_all(5);
        idle(5);

        // Saturation in both modes, INT8 tile starting as soon as INT4 is done.
        start_tile(0, 20);
        for (int b = 0; b < BEATS; b++) begin
            if (b < 8) begin
                for (int k = 0; k < LANES; k++) nx_acc[k] = (k % 2 == 0) ? 100 : -100;
                nx_valid = 1;
                tick();
            end else begin
                beat_rand(b[0]);
            end
        end
        start_tile(1, 36);
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LANES; k++) nx_acc[k] = (k % 2 == 0) ? 200 : -200;
            nx_valid = 1;
            tick();
        end
        idle(5);

        // Half scale on beat 2, bias on beat 4, and a same-cycle rewrite of beat 7.
        set_cfg(2, 16'h0200, 0);
        tick();
        set_cfg(4, 16'h0400, 10);
        tick();
        start_tile(1, 0);
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LANES; k++) nx_acc[k] = (b == 2) ? ((k % 2 == 0) ? 3 : -3) : -10;
            if (b == 7) set_cfg(7, 16'h0800, 5);
            nx_valid = 1;
            tick();
        end
        start_tile(0, 16);
        for (int b = 0; b < BEATS; b++) beat_rand(0);
        idle(5);

        // Valid in IDLE (dropped), then gapped beats with wrap from base 60.
        beat_all(77);
        nx_valid = 1;
        start_tile(1, 60);
        for (int i = 0; i < 2 * BEATS; i++) begin
            for (int k = 0; k < LANES; k++) nx_acc[k] = rand_acc(0);
            nx_valid = (i % 2 == 0);
            tick();
        end
        idle(5);

        // Back-to-back INT8 then INT4 tiles overlapping in flight.
        start_tile(1, 10);
        for (int b = 0; b < BEATS; b++) beat_rand(b[0]);
        for (int k = 0; k < LANES; k++) nx_acc[k] = rand_acc(0);
        nx_valid = 1;
        start_tile(0, 30);
        for (int b = 0; b < BEATS; b++) beat_rand(b[1]);
        idle(5);

        // Reset mid-tile with beats in flight, then a tile on restored tables.
        set_cfg(0, 16'h0123, -50);
        tick();
        start_tile(1, 5);
        for (int b = 0; b < 6; b++) beat_rand(0);
        do_reset();
        idle(1);
        start_tile(1, 40);
        for (int b = 0; b < BEATS; b++) beat_rand(0);
        idle(5);

        // Random tiles: table rewrites, gaps, ignored starts, variable spacing.
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(3)) begin
                set_cfg(int'($urandom_range(BEATS - 1)), int'($urandom_range(16'h0800)),
                        int'($urandom_range(2000)) - 1000);
                for (int k = 0; k < LANES; k++) nx_cfg_scale[k] = int'($urandom_range(16'h0800));
                tick();
            end
            start_tile(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)));
            for (int i = 0; i < 200 && m_run; i++) begin
                for (int k = 0; k < LANES; k++) nx_acc[k] = rand_acc($urandom_range(3) == 0);
                nx_valid = ($urandom_range(9) < 7);
                if ($urandom_range(7) == 0) begin
                    nx_start = 1;
                    nx_mode  = ~m_mode;
                    nx_base  = int'($urandom_range(DEPTH - 1));
                end
                if ($urandom_range(5) == 0)
                    set_cfg(int'($urandom_range(BEATS - 1)), int'($urandom_range(16'h0800)),
                            int'($urandom_range(2000)) - 1000);
                tick();
            end
            check("tile_complete", m_run, 1'b0);
            idle(int'($urandom_range(4)));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
